// File: rtl/bram_read_streamer_if.sv
// rtl/bram_read_streamer_if.sv - BRAM port-B read bus and output stream bundle
interface bram_read_streamer_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              enb;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] doutb;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (
        output enb, addrb, m_data, m_valid, m_last,
        input  doutb, m_ready
    );

    modport slave (
        input  enb, addrb, m_data, m_valid, m_last,
        output doutb, m_ready
    );
endinterface

// File: rtl/bram_read_streamer.sv
// rtl/bram_read_streamer.sv - sweeps a BRAM window into a credit-limited FIFO stream
// Optional running XOR checksum output enabled by BRS_CHECKSUM_EN.
module bram_read_streamer #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK_IN1,
    input  logic              RESET,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
`ifdef BRS_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    bram_read_streamer_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]    OCC_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W+1:0]  CREDIT_MX = (PTR_W+2)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_cur;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_issued;
    logic [ADDR_W:0]   r_popped;
    logic              r_inflight;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_occ;

    logic              w_start_ok;
    logic              w_issue;
    logic              w_push;
    logic              w_valid;
    logic              w_pop;
    logic              w_pop_last;
    logic [PTR_W+1:0]  w_credit_used;

    assign w_start_ok    = (r_state == S_IDLE) && start;
    // Outstanding credit counts the word still in the BRAM pipeline so the FIFO can never overflow.
    assign w_credit_used = {1'b0, r_occ} + {{(PTR_W+1){1'b0}}, r_inflight};
    assign w_issue       = (r_state == S_RUN) && (r_issued < r_count) && (w_credit_used < CREDIT_MX);
    assign w_push        = r_inflight;
    assign w_valid       = (r_occ != '0);
    assign w_pop         = w_valid && bus.m_ready;
    assign w_pop_last    = w_pop && bus.m_last;

    assign bus.enb     = w_issue;
    assign bus.addrb   = r_cur;
    assign bus.m_valid = w_valid;
    assign bus.m_data  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.m_last  = w_valid && (r_popped == (r_count - CNT_ONE));
    assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done        = (r_state == S_FIN);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (word_count == '0) ? S_FIN : S_RUN;
            S_RUN:   if (r_issued == r_count) w_next = S_DRAIN;
            S_DRAIN: if (w_pop_last) w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_IN1) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_cur      <= '0;
            r_count    <= '0;
            r_issued   <= '0;
            r_popped   <= '0;
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_issue;
            if (w_start_ok) begin
                r_cur    <= base_addr;
                r_count  <= word_count;
                r_issued <= '0;
                r_popped <= '0;
            end else begin
                if (w_issue) begin
                    r_cur    <= r_cur + ADDR_ONE;
                    r_issued <= r_issued + CNT_ONE;
                end
                if (w_pop) r_popped <= r_popped + CNT_ONE;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_ONE;
                2'b01:   r_occ <= r_occ - OCC_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge CLK_IN1) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.doutb;
    end

`ifdef BRS_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge CLK_IN1) begin
        if (RESET || w_start_ok) r_checksum <= '0;
        else if (w_pop)          r_checksum <= r_checksum ^ bus.m_data;
    end

    assign checksum = r_checksum;
`endif
endmodule

// File: tb/tb_bram_read_streamer.sv
// tb/tb_bram_read_streamer.sv - randomized self-checking bench for bram_read_streamer
module tb_bram_read_streamer;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int NW = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   word_count = '0;
    logic          busy;
    logic          done;
`ifdef BRS_CHECKSUM_EN
    logic [DW-1:0] checksum;
    logic [DW-1:0] sum_at_done;
`endif

    bram_read_streamer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    bram_read_streamer #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .CLK_IN1    (clk),
        .RESET      (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
`ifdef BRS_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] bram [NW];
    always @(posedge clk) if (bus.enb) bus.doutb <= bram[bus.addrb];

    int total = 0;
    int bad = 0;

    logic [DW-1:0] got_q[$];
    int            addr_q[$];
    int            last_q[$];
    int  done_cnt, done_iter, first_valid_iter, first_acc_iter, last_acc_iter;
    int  enb_cnt, stall_enb, credit_bad, acc;
    bit  busy_at_1, busy_at_done, timed_out;

    function automatic logic [DW-1:0] wexp(input int a);
        int k;
        k = a % NW;
        return {8'((4*k+13) % 256), 8'((4*k+12) % 256), 8'((4*k+11) % 256), 8'((4*k+10) % 256)};
    endfunction

    // mode: 0 ready always, 1 pattern 1,0,0,1, 2 random, 3 stalled for 20 cycles then ready
    task automatic run_xfer(input int b, input int n, input int mode, input int stop_acc, input bit poke);
        int issued;
        bit finished;
        got_q.delete(); addr_q.delete(); last_q.delete();
        done_cnt = 0; done_iter = -1; first_valid_iter = -1; first_acc_iter = -1; last_acc_iter = -1;
        enb_cnt = 0; stall_enb = 0; credit_bad = 0; acc = 0; issued = 0;
        busy_at_1 = 0; busy_at_done = 1; finished = 0;
        @(negedge clk);
        base_addr = AW'(b); word_count = (AW+1)'(n); start = 1'b1;
        for (int i = 1; i < 3000; i++) begin
            @(negedge clk);
            start = poke && (i == 3);
            if (poke && i == 3) begin base_addr = AW'(300); word_count = (AW+1)'(5); end
            case (mode)
                0: bus.m_ready = 1'b1;
                1: bus.m_ready = ((i - 1) % 4 == 0) || ((i - 1) % 4 == 3);
                2: bus.m_ready = 1'($urandom_range(0, 1));
                default: bus.m_ready = (i > 20);
            endcase
            if (i == 1) busy_at_1 = busy;
            if (bus.enb) begin
                addr_q.push_back(int'(bus.addrb));
                if (issued - acc >= DEPTH) credit_bad++;
                issued++; enb_cnt++;
                if (i <= 20) stall_enb++;
            end
            if (bus.m_valid && first_valid_iter < 0) first_valid_iter = i;
            if (done) begin
                done_cnt++;
                if (done_iter < 0) begin
                    done_iter = i; busy_at_done = busy;
`ifdef BRS_CHECKSUM_EN
                    sum_at_done = checksum;
`endif
                end
            end
            if (bus.m_valid && bus.m_ready) begin
                got_q.push_back(bus.m_data);
                if (bus.m_last) last_q.push_back(acc);
                if (first_acc_iter < 0) first_acc_iter = i;
                last_acc_iter = i;
                acc++;
                if (acc == stop_acc) begin finished = 1; break; end
            end
            if (done_iter > 0 && i >= done_iter + 3) begin finished = 1; break; end
        end
        start = 1'b0;
        timed_out = !finished;
    endtask

    task automatic check_stream(input string tag, input int b, input int n);
        int errs;
        total++;
        if (timed_out !== 1'b0) begin bad++; $display("FAIL %s timeout: got=%0d need=0", tag, timed_out); end
        total++;
        if (got_q.size() !== n) begin bad++; $display("FAIL %s word_count: got=%0d need=%0d", tag, got_q.size(), n); end
        errs = 0;
        for (int k = 0; k < got_q.size() && k < n; k++)
            if (got_q[k] !== wexp(b + k)) errs++;
        total++;
        if (errs != 0) begin bad++; $display("FAIL %s data: got=%0d bad words need=0", tag, errs); end
        errs = 0;
        for (int k = 0; k < addr_q.size() && k < n; k++)
            if (addr_q[k] !== (b + k) % NW) errs++;
        total++;
        if (errs != 0 || addr_q.size() != n) begin
            bad++; $display("FAIL %s addr: got=%0d bad of %0d need=0 of %0d", tag, errs, addr_q.size(), n);
        end
        total++;
        if (last_q.size() != 1 || last_q[0] != n - 1) begin
            bad++; $display("FAIL %s last: got=%0d flags need=1 at %0d", tag, last_q.size(), n - 1);
        end
        total++;
        if (done_cnt !== 1 || done_iter !== last_acc_iter + 1) begin
            bad++; $display("FAIL %s done: got=%0d at %0d need=1 at %0d", tag, done_cnt, done_iter, last_acc_iter + 1);
        end
        total++;
        if (credit_bad !== 0) begin bad++; $display("FAIL %s credit: got=%0d need=0", tag, credit_bad); end
    endtask

    task automatic test_reset();
        total++;
        if ({busy, done, bus.enb, bus.m_valid, bus.m_last} !== 5'b0) begin
            bad++; $display("FAIL reset_flags: got=%b need=00000", {busy, done, bus.enb, bus.m_valid, bus.m_last});
        end
        total++;
        if (bus.addrb !== '0) begin bad++; $display("FAIL reset_addrb: got=%0d need=0", bus.addrb); end
        total++;
        if (bus.m_data !== '0) begin bad++; $display("FAIL reset_mdata: got=%h need=0", bus.m_data); end
    endtask

    task automatic test_basic();
        run_xfer(0, 8, 0, -1, 0);
        check_stream("basic", 0, 8);
        total++;
        if (first_valid_iter !== 3) begin bad++; $display("FAIL basic_latency: got=%0d need=3", first_valid_iter); end
        total++;
        if (last_acc_iter - first_acc_iter !== 7) begin
            bad++; $display("FAIL basic_throughput: got=%0d need=7", last_acc_iter - first_acc_iter);
        end
        total++;
        if (busy_at_1 !== 1'b1 || busy_at_done !== 1'b0) begin
            bad++; $display("FAIL basic_busy: got=%b%b need=10", busy_at_1, busy_at_done);
        end
    endtask

    task automatic test_wrap();
        run_xfer(510, 4, 0, -1, 0);
        check_stream("wrap", 510, 4);
    endtask

    task automatic test_backpressure();
        run_xfer(20, 8, 1, -1, 0);
        check_stream("toggle", 20, 8);
        run_xfer(40, 8, 3, -1, 0);
        check_stream("stall", 40, 8);
        total++;
        if (stall_enb !== DEPTH) begin bad++; $display("FAIL stall_issue: got=%0d need=%0d", stall_enb, DEPTH); end
    endtask

    task automatic test_zero_and_ignore();
        run_xfer(5, 0, 0, -1, 0);
        total++;
        if (done_cnt !== 1 || done_iter < 1 || done_iter > 2) begin
            bad++; $display("FAIL zero_done: got=%0d at %0d need=1 at 1..2", done_cnt, done_iter);
        end
        total++;
        if (enb_cnt !== 0 || first_valid_iter !== -1) begin
            bad++; $display("FAIL zero_quiet: got enb=%0d valid_at=%0d need 0 and -1", enb_cnt, first_valid_iter);
        end
        run_xfer(100, 6, 0, -1, 1);
        check_stream("ignore_start", 100, 6);
    endtask

    task automatic test_abort();
        int seen;
        run_xfer(200, 8, 0, 3, 0);
        @(negedge clk);
        rst = 1'b1; start = 1'b1; base_addr = AW'(7); word_count = (AW+1)'(5);
        @(negedge clk);
        total++;
        if ({busy, done, bus.enb, bus.m_valid, bus.m_last} !== 5'b0 || bus.addrb !== '0 || bus.m_data !== '0) begin
            bad++; $display("FAIL abort_outputs: got=%b addr=%0d data=%h need zeros",
                            {busy, done, bus.enb, bus.m_valid, bus.m_last}, bus.addrb, bus.m_data);
        end
        rst = 1'b0; start = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy || bus.enb || bus.m_valid) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL abort_quiet: got=%0d need=0", seen); end
        run_xfer(400, 2, 2, -1, 0);
        check_stream("after_abort", 400, 2);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            run_xfer(int'($urandom_range(0, NW - 1)), int'($urandom_range(1, 40)), 2, -1, 0);
            check_stream($sformatf("random%0d", t), int'(base_addr), int'(word_count));
        end
    endtask

`ifdef BRS_CHECKSUM_EN
    task automatic test_checksum();
        logic [DW-1:0] x;
        x = '0;
        for (int k = 0; k < 4; k++) x ^= wexp(k);
        run_xfer(0, 4, 0, -1, 0);
        total++;
        if (sum_at_done !== x) begin bad++; $display("FAIL checksum: got=%h need=%h", sum_at_done, x); end
    endtask
`endif

    initial begin
        bus.m_ready = 1'b1;
        for (int k = 0; k < NW; k++) bram[k] = wexp(k);
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_and_ignore();
        test_abort();
        test_random();
`ifdef BRS_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
